// File: rtl/oven_pkg.sv
// Shared definitions for the microwave oven controller slice:
// FSM state encodings, power window size and power clamping.
package oven_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ENTRY = 3'b001,
        ST_COOK  = 3'b010,
        ST_PAUSE = 3'b011,
        ST_DONE  = 3'b100
    } state_e;

    localparam int POWER_WINDOW = 10;
    localparam int MAX_POWER    = 10;

    // Out-of-range settings run at full power.
    function automatic logic [3:0] eff_power(input logic [3:0] p);
        if (p == 4'd0 || p > 4'(MAX_POWER)) begin
            return 4'(MAX_POWER);
        end
        return p;
    endfunction

endpackage

// File: rtl/press_detect.sv
// Registered falling-edge detector for an active-low button.
// A held-low button yields exactly one press cycle.
module press_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= btn_ni;
            prev_q <= sync_q;
        end
    end

    assign press_o = prev_q & ~sync_q;

endmodule

// File: rtl/cook_controller.sv
// Microwave cook sequencer: digit-entry gating, 1 Hz decrement strobe,
// power-duty magnetron control, door interlock and end-of-cook beep.
module cook_controller
    import oven_pkg::*;
#(
    parameter int CLK_PER_SEC = 100,
    parameter int BEEP_CYCLES = 50
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       digit_valid,
    input  logic       time_zero,
    input  logic [3:0] power_level,
    output logic       mag_on,
    output logic       timer_load_en,
    output logic       timer_dec,
    output logic       timer_clr,
    output logic       beep,
    output logic [2:0] state
);

    localparam int CNT_MAX = (CLK_PER_SEC > BEEP_CYCLES) ? CLK_PER_SEC : BEEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(CLK_PER_SEC - 1);
    localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
    localparam logic [3:0]       WIN_LAST  = 4'(POWER_WINDOW - 1);

    logic start_p;
    logic stop_p;

    press_detect u_start (
        .clk_i   (clock),
        .rst_ni  (clearn),
        .btn_ni  (startn),
        .press_o (start_p)
    );

    press_detect u_stop (
        .clk_i   (clock),
        .rst_ni  (clearn),
        .btn_ni  (stopn),
        .press_o (stop_p)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [3:0]       win_q, win_d;
    logic             mag_en_q;
    logic             dec_q, dec_d;
    logic             clr_q, clr_d;
    logic             load_q;
    logic             beep_q;

    // sec counter doubles as the beep timer while in DONE
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        win_d   = win_q;
        dec_d   = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (digit_valid) state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (stop_p) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_p && door_closed && !time_zero) begin
                    state_d = ST_COOK;
                    sec_d   = '0;
                    win_d   = '0;
                end
            end
            ST_COOK: begin
                if (stop_p || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (time_zero) begin
                    state_d = ST_DONE;
                    sec_d   = '0;
                end else if (sec_q == SEC_LAST) begin
                    sec_d = '0;
                    dec_d = 1'b1;
                    win_d = (win_q == WIN_LAST) ? 4'd0 : win_q + 4'd1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop_p) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end else if (start_p && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_p || !door_closed || sec_q == BEEP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_IDLE) begin
            sec_d = '0;
            win_d = '0;
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q  <= ST_IDLE;
            sec_q    <= '0;
            win_q    <= '0;
            mag_en_q <= 1'b0;
            dec_q    <= 1'b0;
            clr_q    <= 1'b0;
            load_q   <= 1'b0;
            beep_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec_d;
            win_q    <= win_d;
            mag_en_q <= (state_d == ST_COOK) && (win_d < eff_power(power_level));
            dec_q    <= dec_d;
            clr_q    <= clr_d;
            load_q   <= (state_d == ST_IDLE) || (state_d == ST_ENTRY);
            beep_q   <= (state_d == ST_DONE);
        end
    end

    // Door term stays combinational so opening cuts power immediately.
    assign mag_on        = mag_en_q & door_closed;
    assign timer_load_en = load_q;
    assign timer_dec     = dec_q;
    assign timer_clr     = clr_q;
    assign beep          = beep_q;
    assign state         = state_q;

endmodule
